// File: rtl/pdm_wave_sequencer.sv
// pdm_wave_sequencer
// Sample-rate sequencer for the sine-LUT / dual-PDM datapath. Generates the
// sample tick, walks the channel-1 phase index (channel 2 follows at a fixed
// offset), fetches both samples from a shared LUT over req/ack, rescales the
// signed samples into the unsigned PDM range and publishes both together.

module pdm_wave_sequencer #(
    parameter int NBITS     = 16,
    parameter int IDX_W     = 8,
    parameter int N_SAMPLES = 100,
    parameter int TICK_DIV  = 500,
    parameter int MAX_CURR  = 13080
) (
    input  logic                    i_sys_clk_50M,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic [IDX_W-1:0]        i_phase_ofs,
    input  logic [1:0]              i_gain_shift,
    output logic [IDX_W-1:0]        o_lut_addr,
    output logic                    o_lut_req,
    input  logic                    i_lut_ack,
    input  logic signed [NBITS-1:0] i_lut_data,
    output logic [NBITS-1:0]        o_pdm1_val,
    output logic [NBITS-1:0]        o_pdm2_val,
    output logic                    o_sample_stb,
    output logic                    o_busy,
    output logic                    o_clip,
    output logic                    o_overrun
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int VW    = NBITS + 2;

    localparam logic signed [VW-1:0] MID_V    = VW'(MAX_CURR / 2);
    localparam logic signed [VW-1:0] MAX_V    = VW'(MAX_CURR);
    localparam logic [NBITS-1:0]     MID_OUT  = NBITS'(MAX_CURR / 2);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_SAMPLES - 1);
    localparam logic [IDX_W:0]       N_S      = (IDX_W + 1)'(N_SAMPLES);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        FETCH1,
        GAP,
        FETCH2,
        UPDATE
    } state_t;

    // Rescaled PDM value plus a flag saying the clamp engaged.
    typedef struct packed {
        logic             clip;
        logic [NBITS-1:0] val;
    } conv_t;

    state_t                  state;
    logic [CNT_W-1:0]        tick_cnt;
    logic                    tick;
    logic [IDX_W-1:0]        idx1;
    logic [IDX_W-1:0]        idx2;
    logic [IDX_W:0]          idx_sum;
    logic [IDX_W-1:0]        ofs_q;
    logic [1:0]              shift_q;
    logic signed [NBITS-1:0] s1;
    logic signed [NBITS-1:0] s2;
    logic                    stop_pending;
    logic                    stop_now;
    conv_t                   conv1;
    conv_t                   conv2;

    // Signed sample -> unsigned PDM input: arithmetic shift, re-centre on MID,
    // then clamp into [0, MAX_CURR]. Two guard bits keep the sum from wrapping.
    function automatic conv_t to_pdm(input logic signed [NBITS-1:0] s,
                                     input logic [1:0]              sh);
        logic signed [VW-1:0] se;
        logic signed [VW-1:0] v;
        conv_t                r;
        se = s;
        v  = (se >>> sh) + MID_V;
        if (v < 0) begin
            r.clip = 1'b1;
            r.val  = '0;
        end else if (v > MAX_V) begin
            r.clip = 1'b1;
            r.val  = MAX_V[NBITS-1:0];
        end else begin
            r.clip = 1'b0;
            r.val  = v[NBITS-1:0];
        end
        return r;
    endfunction

    assign conv1    = to_pdm(s1, shift_q);
    assign conv2    = to_pdm(s2, shift_q);
    assign tick     = (state != IDLE) && (tick_cnt == LAST_CNT);
    assign stop_now = stop_pending || i_stop;

    // Channel-2 index: idx1 + offset, folded back into 0..N_SAMPLES-1.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        idx_sum = {1'b0, idx1} + {1'b0, ofs_q};
        idx2    = idx_sum[IDX_W-1:0];
        if (idx_sum >= N_S) begin
            idx2 = IDX_W'(idx_sum - N_S);
        end
    end

    // Sample-rate divider: free-runs while busy, parked at zero in IDLE.
    always_ff @(posedge i_sys_clk_50M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tick_cnt <= '0;
        end else if (state == IDLE || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge i_sys_clk_50M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            idx1         <= '0;
            ofs_q        <= '0;
            shift_q      <= '0;
            s1           <= '0;
            s2           <= '0;
            stop_pending <= 1'b0;
            o_lut_addr   <= '0;
            o_lut_req    <= 1'b0;
            o_pdm1_val   <= MID_OUT;
            o_pdm2_val   <= MID_OUT;
            o_sample_stb <= 1'b0;
            o_busy       <= 1'b0;
            o_clip       <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            o_sample_stb <= 1'b0;

            if (state != IDLE && i_stop) begin
                stop_pending <= 1'b1;
            end

            // A tick while a fetch is still in flight is dropped and flagged.
            if (tick && (state inside {FETCH1, GAP, FETCH2, UPDATE})) begin
                o_overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (i_start && !i_stop) begin
                        ofs_q        <= ({1'b0, i_phase_ofs} >= N_S) ? '0 : i_phase_ofs;
                        shift_q      <= i_gain_shift;
                        idx1         <= '0;
                        o_clip       <= 1'b0;
                        o_overrun    <= 1'b0;
                        stop_pending <= 1'b0;
                        o_busy       <= 1'b1;
                        state        <= WAIT_TICK;
                    end
                end

                WAIT_TICK: begin
                    if (tick) begin
                        o_lut_addr <= idx1;
                        o_lut_req  <= 1'b1;
                        state      <= FETCH1;
                    end
                end

                FETCH1: begin
                    if (i_lut_ack) begin
                        s1        <= i_lut_data;
                        o_lut_req <= 1'b0;
                        state     <= GAP;
                    end
                end

                // One idle request cycle separates the two LUT transactions.
                GAP: begin
                    o_lut_addr <= idx2;
                    o_lut_req  <= 1'b1;
                    state      <= FETCH2;
                end

                FETCH2: begin
                    if (i_lut_ack) begin
                        s2        <= i_lut_data;
                        o_lut_req <= 1'b0;
                        state     <= UPDATE;
                    end
                end

                UPDATE: begin
                    idx1 <= (idx1 == LAST_IDX) ? '0 : idx1 + 1'b1;
                    if (stop_now && idx1 == LAST_IDX) begin
                        // Stop only after a whole period; park outputs at mid-scale.
                        o_pdm1_val   <= MID_OUT;
                        o_pdm2_val   <= MID_OUT;
                        o_busy       <= 1'b0;
                        stop_pending <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        o_pdm1_val   <= conv1.val;
                        o_pdm2_val   <= conv2.val;
                        o_clip       <= o_clip | conv1.clip | conv2.clip;
                        o_sample_stb <= 1'b1;
                        state        <= WAIT_TICK;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_wave_sequencer.sv
// tb_pdm_wave_sequencer
// Directed bench for pdm_wave_sequencer. A LUT responder acknowledges each
// request (optionally after a programmed delay) and logs the addresses; a
// monitor logs every strobe with its values and cycle number. The divider is
// shortened so several full periods fit in a short run.

module tb_pdm_wave_sequencer;

    localparam int NS   = 100;
    localparam int TDIV = 50;
    localparam int MID  = 6540;
    localparam int MAXC = 13080;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic        stop     = 1'b0;
    logic [7:0]  ofs      = '0;
    logic [1:0]  shift    = '0;
    logic [7:0]  lut_addr;
    logic        lut_req;
    logic        lut_ack  = 1'b0;
    logic [15:0] lut_data = '0;
    logic [15:0] pdm1;
    logic [15:0] pdm2;
    logic        stb;
    logic        busy;
    logic        clip;
    logic        overrun;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int start_cyc = 0;

    logic [15:0] lut [0:255];

    int addr_q[$];
    int p1_q[$];
    int p2_q[$];
    int sc_q[$];

    int delay_hs  = -1;
    int delay_len = 0;
    int wait_cnt  = 0;
    int low_run   = 0;
    int gap1_cnt  = 0;

    pdm_wave_sequencer #(
        .NBITS(16), .IDX_W(8), .N_SAMPLES(NS), .TICK_DIV(TDIV), .MAX_CURR(MAXC)
    ) dut (
        .i_sys_clk_50M(clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_stop       (stop),
        .i_phase_ofs  (ofs),
        .i_gain_shift (shift),
        .o_lut_addr   (lut_addr),
        .o_lut_req    (lut_req),
        .i_lut_ack    (lut_ack),
        .i_lut_data   (lut_data),
        .o_pdm1_val   (pdm1),
        .o_pdm2_val   (pdm2),
        .o_sample_stb (stb),
        .o_busy       (busy),
        .o_clip       (clip),
        .o_overrun    (overrun)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // LUT responder: one-cycle ack, optionally delayed for one chosen handshake.
    always @(negedge clk) begin
        if (lut_ack) begin
            lut_ack = 1'b0;
        end else if (lut_req) begin
            if (wait_cnt >= ((addr_q.size() == delay_hs) ? delay_len : 0)) begin
                lut_ack  = 1'b1;
                lut_data = lut[lut_addr];
                addr_q.push_back(int'(lut_addr));
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Strobe log and single-cycle request-gap counter.
    always @(negedge clk) begin
        if (stb) begin
            p1_q.push_back(int'(pdm1));
            p2_q.push_back(int'(pdm2));
            sc_q.push_back(cyc);
        end
        if (lut_req) begin
            if (low_run == 1) gap1_cnt++;
            low_run = 0;
        end else begin
            low_run++;
        end
    end

    function automatic int at(input int q[$], input int i);
        if (i < 0 || i >= q.size()) return -1;
        return q[i];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [7:0] o, input logic [1:0] s, input logic with_stop);
        @(negedge clk);
        ofs   = o;
        shift = s;
        start = 1'b1;
        stop  = with_stop;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int bound, input string tag);
        int n = 0;
        while (p1_q.size() < target && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_timeout"}, 32'(p1_q.size() >= target), 32'd1);
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_req(input int bound, input string tag);
        int n = 0;
        while (lut_req !== 1'b1 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_req"}, 32'(lut_req), 32'd1);
    endtask

    initial begin
        int ba, bs, bg, n;

        for (int i = 0; i < 256; i++) lut[i] = '0;
        lut[25] = 16'd3270;
        lut[98] = 16'd1000;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req",     32'(lut_req),  32'd0);
        check("rst_addr",    32'(lut_addr), 32'd0);
        check("rst_pdm1",    32'(pdm1),     32'(MID));
        check("rst_pdm2",    32'(pdm2),     32'(MID));
        check("rst_stb",     32'(stb),      32'd0);
        check("rst_busy",    32'(busy),     32'd0);
        check("rst_clip",    32'(clip),     32'd0);
        check("rst_overrun", 32'(overrun),  32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(busy),    32'd0);
        check("idle_req",  32'(lut_req), 32'd0);

        // Run A: ofs 25, shift 0, stop requested at idx1 = 40
        ba = addr_q.size(); bs = p1_q.size(); bg = gap1_cnt;
        pulse_start(8'd25, 2'd0, 1'b0);
        wait_strobes(bs + 2, 3 * TDIV, "a_first");
        check("a_latency",  32'(at(sc_q, bs) - start_cyc), 32'(TDIV + 4));
        check("a_pdm1_s0",  32'(at(p1_q, bs)), 32'd6540);
        check("a_pdm2_s0",  32'(at(p2_q, bs)), 32'd9810);
        check("a_addr0",    32'(at(addr_q, ba)), 32'd0);
        check("a_addr1",    32'(at(addr_q, ba + 1)), 32'd25);
        check("a_interval", 32'(at(sc_q, bs + 1) - at(sc_q, bs)), 32'(TDIV));
        check("a_busy",     32'(busy), 32'd1);
        check("a_clip",     32'(clip), 32'd0);
        check("a_overrun",  32'(overrun), 32'd0);
        wait_strobes(bs + 40, 45 * TDIV, "a_idx40");
        pulse_stop();
        wait_idle(70 * TDIV, "a_stop");
        check("a_strobes",  32'(p1_q.size() - bs), 32'd99);
        check("a_hshakes",  32'(addr_q.size() - ba), 32'd200);
        check("a_addr198",  32'(at(addr_q, ba + 198)), 32'd99);
        check("a_addr199",  32'(at(addr_q, ba + 199)), 32'd24);
        check("a_pdm1_s25", 32'(at(p1_q, bs + 25)), 32'd9810);
        check("a_pdm1_s98", 32'(at(p1_q, bs + 98)), 32'd7540);
        check("a_gap1",     32'(gap1_cnt - bg), 32'd100);
        check("a_mid1",     32'(pdm1), 32'(MID));
        check("a_mid2",     32'(pdm2), 32'(MID));
        n = addr_q.size();
        repeat (3 * TDIV) @(negedge clk);
        check("a_no_fetch", 32'(addr_q.size()), 32'(n));
        check("a_req_low",  32'(lut_req), 32'd0);

        // Run B: two periods, ofs 75, shift 2
        lut[5] = 16'(-3270);
        ba = addr_q.size(); bs = p1_q.size(); bg = gap1_cnt;
        pulse_start(8'd75, 2'd2, 1'b0);
        wait_strobes(bs + 110, 120 * TDIV, "b_p2");
        pulse_stop();
        wait_idle(100 * TDIV, "b_stop");
        check("b_strobes",   32'(p1_q.size() - bs), 32'd199);
        check("b_hshakes",   32'(addr_q.size() - ba), 32'd400);
        check("b_addr60",    32'(at(addr_q, ba + 60)), 32'd30);
        check("b_addr61",    32'(at(addr_q, ba + 61)), 32'd5);
        check("b_addr198",   32'(at(addr_q, ba + 198)), 32'd99);
        check("b_addr199",   32'(at(addr_q, ba + 199)), 32'd74);
        check("b_addr200",   32'(at(addr_q, ba + 200)), 32'd0);
        check("b_addr201",   32'(at(addr_q, ba + 201)), 32'd75);
        check("b_pdm2_s30",  32'(at(p2_q, bs + 30)), 32'd5722);
        check("b_pdm1_s5",   32'(at(p1_q, bs + 5)), 32'd5722);
        check("b_pdm1_s25",  32'(at(p1_q, bs + 25)), 32'd7357);
        check("b_pdm2_s50",  32'(at(p2_q, bs + 50)), 32'd7357);
        check("b_pdm1_s125", 32'(at(p1_q, bs + 125)), 32'd7357);
        check("b_clip",      32'(clip), 32'd0);
        check("b_gap1",      32'(gap1_cnt - bg), 32'd200);

        // Run C: out-of-range offset, clamping, delayed ack causing overrun
        lut[0] = 16'h8000;
        lut[1] = 16'h7FFF;
        ba = addr_q.size(); bs = p1_q.size();
        delay_hs  = ba + 2;
        delay_len = 60;
        pulse_start(8'd150, 2'd0, 1'b0);
        wait_strobes(bs + 3, 6 * TDIV, "c_first");
        check("c_addr0",      32'(at(addr_q, ba)), 32'd0);
        check("c_addr1_ofs0", 32'(at(addr_q, ba + 1)), 32'd0);
        check("c_pdm1_low",   32'(at(p1_q, bs)), 32'd0);
        check("c_pdm2_low",   32'(at(p2_q, bs)), 32'd0);
        check("c_pdm1_high",  32'(at(p1_q, bs + 1)), 32'(MAXC));
        check("c_pdm2_high",  32'(at(p2_q, bs + 1)), 32'(MAXC));
        check("c_late_gap",   32'(at(sc_q, bs + 1) - at(sc_q, bs)), 32'(TDIV + 60));
        check("c_realign",    32'(at(sc_q, bs + 2) - at(sc_q, bs + 1)), 32'(2 * TDIV - 60));
        check("c_overrun",    32'(overrun), 32'd1);
        check("c_clip",       32'(clip), 32'd1);
        delay_hs = -1;
        pulse_stop();
        wait_idle(105 * TDIV, "c_stop");
        check("c_overrun_sticky", 32'(overrun), 32'd1);
        check("c_clip_sticky",    32'(clip), 32'd1);

        // Run D: new start clears flags; reset asserted mid-fetch
        lut[0] = 16'd1000;
        lut[1] = '0;
        ba = addr_q.size(); bs = p1_q.size();
        delay_hs  = ba + 2;
        delay_len = 20;
        pulse_start(8'd10, 2'd0, 1'b0);
        check("d_clip_clr",    32'(clip), 32'd0);
        check("d_overrun_clr", 32'(overrun), 32'd0);
        check("d_busy",        32'(busy), 32'd1);
        wait_strobes(bs + 1, 3 * TDIV, "d_first");
        check("d_pdm1_s0", 32'(at(p1_q, bs)), 32'd7540);
        wait_req(2 * TDIV, "d_fetch");
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("d_rst_req",  32'(lut_req), 32'd0);
        check("d_rst_busy", 32'(busy), 32'd0);
        check("d_rst_pdm1", 32'(pdm1), 32'(MID));
        check("d_rst_pdm2", 32'(pdm2), 32'(MID));
        check("d_rst_addr", 32'(lut_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        delay_hs = -1;
        n = addr_q.size();
        repeat (2 * TDIV) @(negedge clk);
        check("d_post_busy",  32'(busy), 32'd0);
        check("d_post_fetch", 32'(addr_q.size()), 32'(n));

        // Start and stop together in IDLE: stays IDLE
        pulse_start(8'd10, 2'd0, 1'b1);
        check("ss_busy0", 32'(busy), 32'd0);
        repeat (2 * TDIV) @(negedge clk);
        check("ss_busy",  32'(busy), 32'd0);
        check("ss_fetch", 32'(addr_q.size()), 32'(n));
        check("ss_req",   32'(lut_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
